// File: rtl/ex_stage_pkg.sv
// Shared encodings and sizes for the execute stage and its mul/div unit.
package ex_stage_pkg;

  localparam int WB_W        = 3;
  localparam int MEM_W       = 12;
  localparam int DATA_W      = 32;
  localparam int MD_ITER_DEF = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100,
    ALU_XOR = 3'b101,
    ALU_NOR = 3'b110,
    ALU_SLL = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_EQ   = 3'b001,
    BR_NE   = 3'b010,
    BR_LEZ  = 3'b011,
    BR_GTZ  = 3'b100
  } br_cond_e;

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MFHI  = 3'b101,
    MD_MFLO  = 3'b110,
    MD_NONE7 = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    FWD_IDEX  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_WB    = 2'b10,
    FWD_IDEX3 = 2'b11
  } fwd_sel_e;

  // Ops that start the iterative unit (MULT, MULTU, DIV, DIVU).
  function automatic logic md_is_start(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Ops that need the unit at all, i.e. must wait while it is busy.
  function automatic logic md_is_used(input logic [2:0] op);
    return (op != MD_NONE) && (op != MD_NONE7);
  endfunction

endpackage

// File: rtl/ex_stage_muldiv_unit.sv
// Iterative multiply/divide: shift-add multiply, restoring divide, sign fix-up, HI/LO.
module muldiv_unit
  import ex_stage_pkg::*;
#(
  parameter int MD_ITER = MD_ITER_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} md_state_e;
  localparam int CNT_W = $clog2(MD_ITER + 1);

  md_state_e        r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [32:0]      r_acc;     // product high half / partial remainder
  logic [31:0]      r_sh;      // multiplier / dividend shifting into quotient
  logic [31:0]      r_m;       // multiplicand / divisor magnitude
  logic             r_is_div, r_neg_q, r_neg_r, r_dz;
  logic [31:0]      r_hi, r_lo;

  logic             w_signed, w_sa, w_sb;
  logic [32:0]      w_mul_sum, w_div_sh;
  logic [33:0]      w_div_sub;
  logic             w_div_ge;
  logic [63:0]      w_prod, w_prod_s;
  logic [31:0]      w_quo, w_rem;

  function automatic logic [31:0] neg_if32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  assign w_signed  = (i_op == MD_MULT) || (i_op == MD_DIV);
  assign w_sa      = w_signed && i_a[31];
  assign w_sb      = w_signed && i_b[31];

  assign w_mul_sum = r_acc + {1'b0, (r_sh[0] ? r_m : 32'd0)};
  assign w_div_sh  = {r_acc[31:0], r_sh[31]};
  assign w_div_sub = {1'b0, w_div_sh} - {2'b00, r_m};
  assign w_div_ge  = ~w_div_sub[33];

  assign w_prod    = {r_acc[31:0], r_sh};
  assign w_prod_s  = r_neg_q ? (~w_prod + 64'd1) : w_prod;
  assign w_quo     = r_dz ? 32'hFFFF_FFFF : neg_if32(r_sh, r_neg_q);
  assign w_rem     = neg_if32(r_acc[31:0], r_neg_r);

  assign o_busy = (r_state != S_IDLE) && !reset;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Next state: start -> MD_ITER iterations -> one fix-up cycle -> idle.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nx = S_ITER;
      S_ITER:  if (r_cnt == CNT_W'(MD_ITER - 1)) w_state_nx = S_FIX;
      S_FIX:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Operand latch, one iteration per cycle, and signed write-back of HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_sh     <= '0;
      r_m      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_cnt    <= '0;
          r_acc    <= '0;
          r_sh     <= neg_if32(i_a, w_sa);
          r_m      <= neg_if32(i_b, w_sb);
          r_is_div <= (i_op == MD_DIV) || (i_op == MD_DIVU);
          r_neg_q  <= w_sa ^ w_sb;
          r_neg_r  <= w_sa;
          r_dz     <= (i_b == 32'd0);
        end
        S_ITER: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_is_div) begin
            r_acc <= w_div_ge ? w_div_sub[32:0] : w_div_sh;
            r_sh  <= {r_sh[30:0], w_div_ge};
          end else begin
            {r_acc, r_sh} <= {w_mul_sum, r_sh} >> 1;
          end
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            {r_hi, r_lo} <= w_prod_s;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, branch evaluation, mul/div issue and the EX/MEM register.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int MD_ITER = MD_ITER_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WB_W-1:0]   WB_in,
  input  logic [MEM_W-1:0]  MEM_in,
  input  logic [31:0]       nextAddress_in,
  input  logic [31:0]       A_in,
  input  logic [31:0]       B_in,
  input  logic [31:0]       imm_in,
  input  logic [4:0]        Ins20_in,
  input  logic [4:0]        Ins15_in,
  input  logic [4:0]        Ins10_in,
  input  logic [2:0]        AluzeroCtr,
  input  logic              RegDst,
  input  logic [2:0]        ALUop,
  input  logic              ALUSrc,
  input  logic [2:0]        md_op,
  input  logic [1:0]        fwdA,
  input  logic [1:0]        fwdB,
  input  logic [31:0]       wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              md_busy,
  output logic [WB_W-1:0]   WB_out,
  output logic [MEM_W-1:0]  MEM_out,
  output logic [31:0]       alu_out,
  output logic [31:0]       store_out,
  output logic [4:0]        dest_out,
  output logic              br_taken_out,
  output logic [31:0]       br_target_out
);

  logic [WB_W-1:0]    r_wb_p0;
  logic [MEM_W-1:0]   r_mem_p0;
  logic [31:0]        r_alu_p0, r_store_p0, r_tgt_p0;
  logic [4:0]         r_dest_p0;
  logic               r_br_p0;

  logic [31:0]        w_opA, w_fB, w_opB, w_alu, w_res, w_hi, w_lo;
  logic signed [31:0] w_opA_s, w_opB_s;
  logic               w_br, w_busy, w_stall, w_issue;

  function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] idex,
                                          input logic [31:0] exmem, input logic [31:0] wb);
    case (sel)
      FWD_EXMEM: return exmem;
      FWD_WB:    return wb;
      default:   return idex;
    endcase
  endfunction

  assign w_opA   = fwd_mux(fwdA, A_in, r_alu_p0, wb_data);
  assign w_fB    = fwd_mux(fwdB, B_in, r_alu_p0, wb_data);
  assign w_opB   = ALUSrc ? imm_in : w_fB;
  assign w_opA_s = signed'(w_opA);
  assign w_opB_s = signed'(w_opB);

  assign w_stall = w_busy && md_is_used(md_op);
  assign w_issue = md_is_start(md_op) && !w_stall && !flush;

  // ALU function select.
  always_comb begin
    w_alu = '0;
    case (ALUop)
      ALU_ADD: w_alu = w_opA + w_opB;
      ALU_SUB: w_alu = w_opA - w_opB;
      ALU_AND: w_alu = w_opA & w_opB;
      ALU_OR:  w_alu = w_opA | w_opB;
      ALU_SLT: w_alu = {31'd0, (w_opA_s < w_opB_s)};
      ALU_XOR: w_alu = w_opA ^ w_opB;
      ALU_NOR: w_alu = ~(w_opA | w_opB);
      ALU_SLL: w_alu = w_opB << Ins10_in;
      default: w_alu = '0;
    endcase
  end

  // Result select: HI/LO moves override the ALU.
  always_comb begin
    w_res = w_alu;
    if (md_op == MD_MFHI)      w_res = w_hi;
    else if (md_op == MD_MFLO) w_res = w_lo;
  end

  // Branch condition evaluation.
  always_comb begin
    w_br = 1'b0;
    case (AluzeroCtr)
      BR_EQ:   w_br = (w_opA == w_fB);
      BR_NE:   w_br = (w_opA != w_fB);
      BR_LEZ:  w_br = (w_opA_s <= 32'sd0);
      BR_GTZ:  w_br = (w_opA_s >  32'sd0);
      default: w_br = 1'b0;
    endcase
  end

  muldiv_unit #(.MD_ITER(MD_ITER)) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_issue),
    .i_op    (md_op),
    .i_a     (w_opA),
    .i_b     (w_fB),
    .o_busy  (w_busy),
    .o_hi    (w_hi),
    .o_lo    (w_lo)
  );

  // EX/MEM register: stall and flush both insert an all-zero bubble.
  always_ff @(posedge clk) begin
    if (reset || w_stall || flush) begin
      r_wb_p0    <= '0;
      r_mem_p0   <= '0;
      r_alu_p0   <= '0;
      r_store_p0 <= '0;
      r_dest_p0  <= '0;
      r_br_p0    <= 1'b0;
      r_tgt_p0   <= '0;
    end else begin
      r_wb_p0    <= WB_in;
      r_mem_p0   <= MEM_in;
      r_alu_p0   <= w_res;
      r_store_p0 <= w_fB;
      r_dest_p0  <= RegDst ? Ins15_in : Ins20_in;
      r_br_p0    <= w_br;
      r_tgt_p0   <= nextAddress_in + (imm_in << 2);
    end
  end

  assign stall         = w_stall;
  assign md_busy       = w_busy;
  assign WB_out        = r_wb_p0;
  assign MEM_out       = r_mem_p0;
  assign alu_out       = r_alu_p0;
  assign store_out     = r_store_p0;
  assign dest_out      = r_dest_p0;
  assign br_taken_out  = r_br_p0;
  assign br_target_out = r_tgt_p0;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus random traffic against a reference model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  WB_in;
  logic [11:0] MEM_in;
  logic [31:0] nextAddress_in, A_in, B_in, imm_in, wb_data;
  logic [4:0]  Ins20_in, Ins15_in, Ins10_in;
  logic [2:0]  AluzeroCtr, ALUop, md_op;
  logic        RegDst, ALUSrc, flush;
  logic [1:0]  fwdA, fwdB;
  logic        stall, md_busy, br_taken_out;
  logic [2:0]  WB_out;
  logic [11:0] MEM_out;
  logic [31:0] alu_out, store_out, br_target_out;
  logic [4:0]  dest_out;

  always #5 clk = ~clk;

  ex_stage #(.MD_ITER(32)) dut (
    .clk(clk), .reset(reset), .WB_in(WB_in), .MEM_in(MEM_in),
    .nextAddress_in(nextAddress_in), .A_in(A_in), .B_in(B_in), .imm_in(imm_in),
    .Ins20_in(Ins20_in), .Ins15_in(Ins15_in), .Ins10_in(Ins10_in),
    .AluzeroCtr(AluzeroCtr), .RegDst(RegDst), .ALUop(ALUop), .ALUSrc(ALUSrc),
    .md_op(md_op), .fwdA(fwdA), .fwdB(fwdB), .wb_data(wb_data), .flush(flush),
    .stall(stall), .md_busy(md_busy), .WB_out(WB_out), .MEM_out(MEM_out),
    .alu_out(alu_out), .store_out(store_out), .dest_out(dest_out),
    .br_taken_out(br_taken_out), .br_target_out(br_target_out)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state: architectural view of the EX/MEM bundle and the mul/div unit.
  logic [2:0]  m_wb;
  logic [11:0] m_mem;
  logic [31:0] m_alu, m_store, m_tgt, m_hi, m_lo, m_phi, m_plo;
  logic [4:0]  m_dest;
  logic        m_br;
  int          m_cnt;      // cycles of busy remaining
  logic        obs_stall;

  task automatic clr_in();
    WB_in = 0; MEM_in = 0; nextAddress_in = 0; A_in = 0; B_in = 0; imm_in = 0;
    wb_data = 0; Ins20_in = 0; Ins15_in = 0; Ins10_in = 0; AluzeroCtr = 0;
    ALUop = 0; md_op = 0; RegDst = 0; ALUSrc = 0; flush = 0; fwdA = 0; fwdB = 0;
  endtask

  task automatic rnd_in();
    int r;
    WB_in = 3'($urandom); MEM_in = 12'($urandom); nextAddress_in = $urandom;
    A_in = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
    B_in = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
    if ($urandom_range(0, 3) == 0) B_in = 32'($urandom_range(0, 9)) - 32'd4;
    imm_in = $urandom; wb_data = $urandom;
    Ins20_in = 5'($urandom); Ins15_in = 5'($urandom); Ins10_in = 5'($urandom);
    AluzeroCtr = 3'($urandom); ALUop = 3'($urandom); RegDst = 1'($urandom);
    ALUSrc = 1'($urandom); fwdA = 2'($urandom); fwdB = 2'($urandom);
    r = $urandom_range(0, 15);
    md_op = (r < 11) ? 3'd0 : 3'($urandom_range(1, 7));
    flush = ($urandom_range(0, 15) == 0);
    reset = ($urandom_range(0, 199) == 0);
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model, check registers.
  task automatic step();
    logic        s;
    logic [31:0] a, fb, ob, res;
    logic        br;
    longint      sa, sb, q, rm;
    longint unsigned up;
    @(negedge clk);
    s = !reset && (m_cnt > 0) && (md_op >= 3'd1) && (md_op <= 3'd6);
    obs_stall = stall;
    chk("stall", stall, s);
    chk("md_busy", md_busy, !reset && (m_cnt > 0));
    a  = (fwdA == 2'd1) ? m_alu : (fwdA == 2'd2) ? wb_data : A_in;
    fb = (fwdB == 2'd1) ? m_alu : (fwdB == 2'd2) ? wb_data : B_in;
    ob = ALUSrc ? imm_in : fb;
    case (ALUop)
      3'd0: res = a + ob;
      3'd1: res = a - ob;
      3'd2: res = a & ob;
      3'd3: res = a | ob;
      3'd4: res = ($signed(a) < $signed(ob)) ? 32'd1 : 32'd0;
      3'd5: res = a ^ ob;
      3'd6: res = ~(a | ob);
      default: res = ob << Ins10_in;
    endcase
    if (md_op == 3'd5) res = m_hi;
    if (md_op == 3'd6) res = m_lo;
    case (AluzeroCtr)
      3'd1: br = (a == fb);
      3'd2: br = (a != fb);
      3'd3: br = ($signed(a) <= 0);
      3'd4: br = ($signed(a) > 0);
      default: br = 1'b0;
    endcase
    @(posedge clk);
    #1;
    if (reset) begin
      m_wb = 0; m_mem = 0; m_alu = 0; m_store = 0; m_dest = 0; m_br = 0; m_tgt = 0;
      m_hi = 0; m_lo = 0; m_cnt = 0;
    end else begin
      if (s || flush) begin
        m_wb = 0; m_mem = 0; m_alu = 0; m_store = 0; m_dest = 0; m_br = 0; m_tgt = 0;
      end else begin
        m_wb = WB_in; m_mem = MEM_in; m_alu = res; m_store = fb;
        m_dest = RegDst ? Ins15_in : Ins20_in; m_br = br;
        m_tgt = nextAddress_in + imm_in * 4;
      end
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin m_hi = m_phi; m_lo = m_plo; end
      end else if (md_op >= 3'd1 && md_op <= 3'd4 && !flush) begin
        m_cnt = 33;
        sa = longint'($signed(a));
        sb = longint'($signed(fb));
        case (md_op)
          3'd1: begin up = longint'(sa * sb); {m_phi, m_plo} = up; end
          3'd2: begin up = longint'(a) * longint'(fb); {m_phi, m_plo} = up; end
          3'd3: if (fb == 0) begin m_plo = 32'hFFFF_FFFF; m_phi = a; end
                else begin q = sa / sb; rm = sa % sb; m_plo = q[31:0]; m_phi = rm[31:0]; end
          default: if (fb == 0) begin m_plo = 32'hFFFF_FFFF; m_phi = a; end
                   else begin m_plo = a / fb; m_phi = a % fb; end
        endcase
      end
    end
    chk("WB_out", WB_out, m_wb);
    chk("MEM_out", MEM_out, m_mem);
    chk("alu_out", alu_out, m_alu);
    chk("store_out", store_out, m_store);
    chk("dest_out", dest_out, m_dest);
    chk("br_taken_out", br_taken_out, m_br);
    chk("br_target_out", br_target_out, m_tgt);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    md_op = 0;
    while (md_busy && n < 40) begin step(); n++; end
    chk({tag, "_idle"}, md_busy, 1'b0);
  endtask

  task automatic md_run(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    clr_in(); md_op = op; A_in = a; B_in = b; step();
    wait_idle(tag);
    md_op = 3'd6; step(); chk({tag, "_lo"}, alu_out, elo);
    md_op = 3'd5; step(); chk({tag, "_hi"}, alu_out, ehi);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    m_wb = 0; m_mem = 0; m_alu = 0; m_store = 0; m_dest = 0; m_br = 0; m_tgt = 0;
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_cnt = 0; obs_stall = 0;
    clr_in(); reset = 1'b1;
    step(); step();
    chk("rst_alu", alu_out, 32'd0);
    chk("rst_wb", WB_out, 3'd0);
    reset = 1'b0;

    // ALU overflow wrap and rd destination.
    clr_in(); A_in = 32'h7FFF_FFFF; B_in = 32'd1; RegDst = 1; Ins15_in = 5'd5; WB_in = 3'b101;
    MEM_in = 12'hA5C; step();
    chk("t1_alu", alu_out, 32'h8000_0000);
    chk("t1_dest", dest_out, 5'd5);
    chk("t1_wb", WB_out, 3'b101);

    // Forwarding from EX/MEM and MEM/WB feeding a BEQ.
    clr_in(); A_in = 32'h10; step();
    clr_in(); fwdA = 2'b01; fwdB = 2'b10; wb_data = 32'h10; AluzeroCtr = 3'd1;
    imm_in = 32'd3; nextAddress_in = 32'h100; step();
    chk("t2_br", br_taken_out, 1'b1);
    chk("t2_tgt", br_target_out, 32'h10C);

    // MULT followed by a dependent MFLO: 33 stalled cycles then the result.
    clr_in(); md_op = 3'd1; A_in = 32'hFFFF_FFFE; B_in = 32'd3; step();
    md_op = 3'd6; WB_in = 3'b111; MEM_in = 12'hFFF; n = 0;
    step();
    while (obs_stall && n < 40) begin n++; step(); end
    chk("t3_stall_cycles", n, 33);
    chk("t3_mflo", alu_out, 32'hFFFF_FFFA);
    md_op = 3'd5; step();
    chk("t3_mfhi", alu_out, 32'hFFFF_FFFF);

    // Signed division and divide-by-zero.
    md_run("t4_div", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md_run("t4_divu0", 3'd4, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    md_run("t4_div_min", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    md_run("t4_mult_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);

    // Reset in the middle of a DIVU.
    clr_in(); md_op = 3'd4; A_in = 32'd100; B_in = 32'd7; step();
    md_op = 3'd0;
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1; step();
    chk("t5_busy", md_busy, 1'b0);
    chk("t5_stall", stall, 1'b0);
    reset = 1'b0; md_op = 3'd5; step();
    chk("t5_hi", alu_out, 32'd0);
    md_op = 3'd6; step();
    chk("t5_lo", alu_out, 32'd0);

    // Independent ALU op flows while busy; flush suppresses an issue.
    clr_in(); md_op = 3'd2; A_in = 32'd9; B_in = 32'd9; step();
    clr_in(); A_in = 32'd3; B_in = 32'd4; WB_in = 3'b010; step();
    chk("t6_nostall", obs_stall, 1'b0);
    chk("t6_add", alu_out, 32'd7);
    wait_idle("t6");
    clr_in(); md_op = 3'd1; flush = 1; WB_in = 3'b111; MEM_in = 12'h123; A_in = 32'd2; B_in = 32'd2;
    step();
    chk("t6_flush_wb", WB_out, 3'd0);
    chk("t6_flush_mem", MEM_out, 12'd0);
    chk("t6_flush_busy", md_busy, 1'b0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rnd_in();
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage. It consumes the decoded bundle presented by the ID/EX pipeline register and produces the registered EX/MEM bundle.
- Contains:
  - operand forwarding muxes
  - 3-bit-op ALU
  - branch-condition evaluation and branch-target adder
  - an iterative 33-cycle multiply/divide unit with HI/LO registers
- Raises `stall` to freeze IF/ID and ID/EX while a mul/div result is pending.

Parameters:
- `MD_ITER`, 32, shift/add or subtract iterations per mul/div op. Total busy time is `MD_ITER`+1 cycles.

Ports:
- `clk` input 1: the single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `WB_in` input 3: write-back control from ID/EX.
- `MEM_in` input 12: memory control from ID/EX.
- `nextAddress_in` input 32: PC+4 from ID/EX.
- `A_in` input 32: rs value from ID/EX.
- `B_in` input 32: rt value from ID/EX.
- `imm_in` input 32: sign-extended immediate.
- `Ins20_in` input 5: rt field.
- `Ins15_in` input 5: rd field.
- `Ins10_in` input 5: shamt field.
- `AluzeroCtr` input 3: branch condition select.
- `RegDst` input 1: 1 selects rd, 0 selects rt.
- `ALUop` input 3: ALU function.
- `ALUSrc` input 1: 1 selects imm, 0 selects forwarded B.
- `md_op` input 3: mul/div function.
- `fwdA` input 2: forwarding select for operand A.
- `fwdB` input 2: forwarding select for operand B. Both selects: 00 = ID/EX value, 01 = EX/MEM `alu_out`, 10 = `wb_data`, 11 = ID/EX value.
- `wb_data` input 32: MEM/WB write-back value.
- `flush` input 1: squash the instruction in EX.
- `stall` output 1: combinational; holds upstream stages.
- `md_busy` output 1: mul/div in progress.
- `WB_out` output 3: registered.
- `MEM_out` output 12: registered.
- `alu_out` output 32: registered.
- `store_out` output 32: registered forwarded B, used as store data.
- `dest_out` output 5: registered destination register.
- `br_taken_out` output 1: registered branch condition.
- `br_target_out` output 32: registered branch target.

Behaviour:
- **Reset.** Every registered output, HI, LO and the mul/div FSM clear to 0 at the next edge. `stall` and `md_busy` are 0 during and after reset. Reset mid-operation aborts the mul/div unit; HI/LO end at 0.
- **Operands.**
  - `opA` = forwarded A.
  - `fB` = forwarded B.
  - `opB` = `ALUSrc` ? `imm_in` : `fB`.
- **ALUop encoding.**
  - 000 ADD (wrap mod 2^32, no overflow trap)
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 SLT (signed; result 1 or 0)
  - 101 XOR
  - 110 NOR
  - 111 SLL: `opB << Ins10_in`
- **AluzeroCtr encoding.**
  - 000 none: `br_taken`=0
  - 001 BEQ: `opA==fB`
  - 010 BNE: `opA!=fB`
  - 011 BLEZ: `opA<=0` signed
  - 100 BGTZ: `opA>0` signed
  - 101–111: `br_taken`=0
- **Branch target.** `br_target` = `nextAddress_in + (imm_in<<2)`.
- **Destination.** `dest` = `RegDst` ? `Ins15_in` : `Ins20_in`.
- **md_op encoding.**
  - 000 none
  - 001 MULT
  - 010 MULTU
  - 011 DIV
  - 100 DIVU
  - 101 MFHI
  - 110 MFLO
  - 111 none
  - MFHI/MFLO place HI/LO on `alu_out` instead of the ALU result.
- **Mul/div FSM states.**
  - IDLE → ITER: on an issue (`md_op` 001–100, not stalled, not flushed). Latch operand magnitudes and result signs.
  - ITER: one shift-add (mul) or restoring-subtract (div) step per cycle for `MD_ITER` cycles.
  - FIX: apply signs, then write HI/LO.
  - FIX → IDLE.
  - `md_busy` is high in ITER and FIX, i.e. exactly 33 cycles after the issue edge. HI/LO become visible the cycle `md_busy` falls.
- **Results.**
  - MULT/MULTU: {HI,LO} = 64-bit product.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero; remainder takes the dividend's sign.
  - Divide by zero: LO = 0xFFFFFFFF, HI = dividend, no exception.
- **Stall.** `stall` = `md_busy` & (`md_op` != none). Non-mul/div instructions flow during `md_busy`.
- **EX/MEM register update.**
  - On `stall` or `flush`: `WB_out`=0 and `MEM_out`=0 (bubble). Other fields load don't-care, which is implemented as 0.
  - Issue cycle of MULT/DIV: EX/MEM receives the instruction's own WB/MEM bundle; decode drives zeros there.
  - `flush` with `stall` both high: bubble; the FSM is unaffected.
  - `flush` on an issue cycle suppresses the issue.

Decomposition:
- Shared package holds:
  - ALUop, AluzeroCtr and md_op encodings
  - forwarding-select codes
  - WB/MEM bundle widths (3 and 12)
  - `MD_ITER` default
- One sub-module, `muldiv_unit`: FSM, HI/LO registers, busy flag. Interface is start/op/operands in, busy/HI/LO out.
- ALU, forwarding and the EX/MEM register stay in `ex_stage`.

Test Plan:
1. **ALU/destination.** ADD with A=0x7FFFFFFF, B=1, ALUSrc=0, RegDst=1, Ins15=5 → next edge: alu_out=0x80000000, dest_out=5, WB_out=WB_in.
2. **Forwarding/branch.** fwdA=01 with previous alu_out=0x10; fwdB=10 with wb_data=0x10; AluzeroCtr=001; imm=3; nextAddress=0x100 → br_taken_out=1, br_target_out=0x10C.
3. **MULT timing.** MULT A=0xFFFFFFFE (−2), B=3, then MFLO next cycle → stall=1 for 33 cycles with bubbles in EX/MEM. Then alu_out=0xFFFFFFFA; MFHI gives 0xFFFFFFFF.
4. **Division.** DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 5/0 → LO=0xFFFFFFFF, HI=5.
5. **Reset mid-op.** Reset asserted at iteration 10 of DIVU → next edge: md_busy=0, HI=LO=0, all outputs 0, stall=0.
6. **Flush/stall precedence.** ADD issued while md_busy=1 → no stall, result after 1 cycle. flush=1 concurrent with MULT issue → WB_out=0, MEM_out=0, md_busy stays 0.
